result_drain: RTL and testbench

- Output-side counterpart of the tensor-core sequencer. The sequencer streams operands into the 2x2 systolic array and pulses push11, pushedge and push22 as each 2x2 result tile completes.
- This block captures the four 32-bit accumulator results on those pulses and buffers whole tiles in a small FIFO. It then serialises the tiles as 32-bit words over a valid/ready stream to the memory writer.
- It also tracks tile count and reports end-of-operation once every tile has drained.

---
 rtl/result_drain.sv | 113 +++++++++++
 tb/tb_result_drain.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// result_drain: capture 2x2 result tiles, buffer them in a tile FIFO and serialise them as words
module result_drain #(
  parameter int DEPTH = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push11,
  input  logic          pushedge,
  input  logic          push22,
  input  logic          op_valid,
  input  logic [DW-1:0] c11,
  input  logic [DW-1:0] c12,
  input  logic [DW-1:0] c21,
  input  logic [DW-1:0] c22,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [31:0]   tile_idx,
  output logic          overflow,
  output logic          seq_err,
  output logic          drain_done
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {W11, WEDGE, W22} state_t;
  state_t state;
  logic [DW-1:0] r11, r12, r21;
  logic [4*DW-1:0] mem [DEPTH];
  logic [4*DW-1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [1:0] ptr;
  logic [31:0] wr_cnt, total;
  logic op_seen, multi, err, tile_in, pop, pop_last, full, empty, do_wr;
  // Strobe checking, FIFO status and word selection for the head tile
  always_comb begin
    multi = (push11 & pushedge) | (push11 & push22) | (pushedge & push22);
    err = multi | (push11 & (state != W11)) | (pushedge & (state != WEDGE)) | (push22 & (state != W22));
    tile_in = push22 & ~err;
    empty = count == '0;
    full = count == (AW+1)'(DEPTH);
    out_valid = ~empty;
    pop = out_valid & out_ready;
    pop_last = pop & (ptr == 2'd3);
    do_wr = tile_in & (~full | pop_last);
    head = mem[rd_ptr];
    out_data = ~out_valid ? '0 :
               ptr == 2'd0 ? head[4*DW-1 -: DW] :
               ptr == 2'd1 ? head[3*DW-1 -: DW] :
               ptr == 2'd2 ? head[2*DW-1 -: DW] : head[DW-1:0];
    out_last = out_valid & op_seen & (ptr == 2'd3) & (tile_idx == total - 32'd1);
    drain_done = op_seen & empty;
  end
  // Capture FSM; a stray push11 restarts capture, any other error discards the partial tile
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= W11;
      seq_err <= 1'b0;
    end else begin
      if (err) seq_err <= 1'b1;
      if (push11) begin
        r11 <= c11;
        state <= WEDGE;
      end else if (pushedge & ~err) begin
        r12 <= c12;
        r21 <= c21;
        state <= W22;
      end else if (push22 | err) state <= W11;
    end
  end
  // Tile storage, written with c22 straight from the input on the completing strobe
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= {r11, r12, r21, c22};
  end
  // FIFO pointers, word pointer and overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ptr <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (tile_in & ~do_wr) overflow <= 1'b1;
      if (pop) ptr <= ptr + 2'd1;
      if (pop_last) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(pop_last);
    end
  end
  // Tile accounting and end-of-operation tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt <= '0;
      total <= '0;
      tile_idx <= '0;
      op_seen <= 1'b0;
    end else if (drain_done & ~op_valid) begin
      op_seen <= 1'b0;
      total <= '0;
      tile_idx <= '0;
      wr_cnt <= {31'b0, do_wr};
    end else begin
      if (do_wr) wr_cnt <= wr_cnt + 32'd1;
      if (pop_last) tile_idx <= tile_idx + 32'd1;
      if (op_valid) begin
        op_seen <= 1'b1;
        total <= wr_cnt + {31'b0, do_wr};
      end
    end
  end
endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: directed scoreboard bench for result_drain
module tb_result_drain;
  logic clk = 0, reset, push11, pushedge, push22, op_valid, out_ready;
  logic [31:0] c11, c12, c21, c22, out_data, tile_idx;
  logic out_valid, out_last, overflow, seq_err, drain_done;
  logic [32:0] q[$];
  logic [32:0] e;
  int n_cmp = 0, n_bad = 0;

  result_drain #(.DEPTH(4), .DW(32)) dut (
    .clk(clk), .reset(reset), .push11(push11), .pushedge(pushedge), .push22(push22),
    .op_valid(op_valid), .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .tile_idx(tile_idx), .overflow(overflow), .seq_err(seq_err), .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tile(input logic [31:0] a, b, c, d, input bit acc, lst, ov);
    c11 = a; push11 = 1; cyc();
    push11 = 0; c12 = b; c21 = c; pushedge = 1; cyc();
    pushedge = 0; c22 = d; push22 = 1; op_valid = ov;
    if (acc) begin
      q.push_back({1'b0, a}); q.push_back({1'b0, b});
      q.push_back({1'b0, c}); q.push_back({lst, d});
    end
    cyc();
    push22 = 0; op_valid = 0;
  endtask

  task automatic op_pulse();
    op_valid = 1; cyc(); op_valid = 0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (q.size() == 0) break;
    end
    #1;
    chk({tag, "_drained"}, q.size(), 0);
    @(negedge clk);
    chk({tag, "_done"}, drain_done, 1);
    chk({tag, "_empty"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, drain_done, 0);
    cyc();
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_word", out_data, 64'hdead);
      else begin
        e = q.pop_front();
        chk("word", out_data, e[31:0]);
        chk("last", out_last, e[32]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; push11 = 0; pushedge = 0; push22 = 0; op_valid = 0; out_ready = 0;
    c11 = 0; c12 = 0; c21 = 0; c22 = 0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_idx", tile_idx, 0);
    chk("rst_flags", {overflow, seq_err, drain_done}, 0);
    cyc();
    reset = 0;
    cyc();

    // single tile, op_valid together with push22
    out_ready = 1;
    tile(5, -3, 7, 100, 1, 1, 1);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 5);
    wait_drain("single");

    // backpressure across two tiles
    out_ready = 0;
    tile(11, 12, 13, 14, 1, 0, 0);
    tile(21, 22, 23, 24, 1, 1, 0);
    op_pulse();
    out_ready = 1; cyc();
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold", out_data, 12);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_idx0", tile_idx, 0);
      cyc();
    end
    out_ready = 1; cyc(); cyc(); cyc();
    @(negedge clk);
    chk("bp_idx1", tile_idx, 1);
    chk("bp_b11", out_data, 21);
    wait_drain("bp");

    // overflow: fifth tile dropped
    out_ready = 0;
    for (int i = 0; i < 4; i++) tile(100 + 4 * i, 101 + 4 * i, 102 + 4 * i, 103 + 4 * i, 1, i == 3, 0);
    @(negedge clk);
    chk("ovf_before", overflow, 0);
    cyc();
    tile(900, 901, 902, 903, 0, 0, 0);
    @(negedge clk);
    chk("ovf_set", overflow, 1);
    cyc();
    op_pulse();
    out_ready = 1;
    wait_drain("ovf");
    chk("ovf_sticky", overflow, 1);

    // reset mid-drain with a tile popped and another queued
    out_ready = 0;
    tile(31, 32, 33, 34, 1, 0, 0);
    tile(41, 42, 43, 44, 1, 0, 0);
    out_ready = 1; cyc(); cyc(); cyc(); cyc();
    out_ready = 0;
    @(negedge clk);
    chk("rmd_idx_before", tile_idx, 1);
    cyc();
    reset = 1; q.delete(); cyc();
    reset = 0;
    @(negedge clk);
    chk("rmd_valid", out_valid, 0);
    chk("rmd_idx", tile_idx, 0);
    chk("rmd_ovf", overflow, 0);
    cyc();
    out_ready = 1;
    tile(51, -52, 53, -54, 1, 1, 1);
    wait_drain("rmd");

    // op_valid with no tiles written
    op_pulse();
    @(negedge clk);
    chk("zero_done", drain_done, 1);
    @(negedge clk);
    chk("zero_pulse", drain_done, 0);
    cyc();

    // FIFO full, head tile's last word popped in the push22 cycle
    out_ready = 0;
    for (int i = 0; i < 4; i++) tile(200 + 4 * i, 201 + 4 * i, 202 + 4 * i, 203 + 4 * i, 1, 0, 0);
    out_ready = 1; cyc();
    tile(300, 301, 302, 303, 1, 1, 0);
    out_ready = 0;
    @(negedge clk);
    chk("fsp_ovf", overflow, 0);
    chk("fsp_idx", tile_idx, 1);
    cyc();
    op_pulse();
    out_ready = 1;
    wait_drain("fsp");

    // sequence error followed by a clean tile
    pushedge = 1; cyc();
    pushedge = 0;
    @(negedge clk);
    chk("seq_err", seq_err, 1);
    chk("seq_nowrite", out_valid, 0);
    cyc();
    tile(61, 62, 63, 64, 1, 1, 1);
    wait_drain("seq");
    chk("seq_sticky", seq_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
